// File: rtl/shift8_seq_pkg.sv
// shift8_seq_pkg
//   Shared definitions for the sequential 8-bit shift unit:
//   operation encodings, FSM state encodings, the per-step shift
//   limit of the combinational stage, and the step clamp helper.
package shift8_seq_pkg;

  typedef enum logic [1:0] {
    OP_LSL  = 2'b00,
    OP_LSR  = 2'b01,
    OP_ASR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Largest shift the combinational stage performs in one cycle.
  localparam int unsigned STEP_LIMIT = 3;

  // Amount to take from the remaining total this cycle.
  function automatic logic [1:0] clamp_step(input logic [2:0] rem);
    if (rem > 3'(STEP_LIMIT)) begin
      return 2'(STEP_LIMIT);
    end
    return rem[1:0];
  endfunction

endpackage

// File: rtl/shift8_seq_if.sv
// shift8_seq_if
//   Start/done handshake bundle of shift8_seq.
//   start  : request, sampled only in IDLE or DONE
//   op     : 00 LSL, 01 LSR, 10 ASR, 11 pass
//   d_in   : operand, latched on accepted start
//   shamt  : total shift amount 0-7, latched on accepted start
//   busy   : high while shifting
//   done   : one-cycle pulse, result valid on d_out
//   d_out  : working register / final result
//   master : requester side; slave : shift8_seq side.
interface shift8_seq_if;

  logic       start;
  logic [1:0] op;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  modport master (
    output start,
    output op,
    output d_in,
    output shamt,
    input  busy,
    input  done,
    input  d_out
  );

  modport slave (
    input  start,
    input  op,
    input  d_in,
    input  shamt,
    output busy,
    output done,
    output d_out
  );

endinterface

// File: rtl/shift8_seq_shifter8.sv
// shifter8
//   Combinational 8-bit shift stage, 0-3 positions per use.
//   d  : operand
//   op : LSL (zero-fill LSBs), LSR (zero-fill MSBs),
//        ASR (replicate d[7] into MSBs), PASS (no shift)
//   sh : shift amount 0-3
//   q  : shifted result
module shifter8
  import shift8_seq_pkg::*;
(
  input  logic [7:0] d,
  input  op_e        op,
  input  logic [1:0] sh,
  output logic [7:0] q
);

  logic [7:0] fill_mask;

  // Ones in the MSB positions vacated by a right shift.
  assign fill_mask = ~(8'hFF >> sh);

  always_comb begin
    q = d;
    case (op)
      OP_LSL:  q = d << sh;
      OP_LSR:  q = d >> sh;
      OP_ASR:  q = (d >> sh) | (fill_mask & {8{d[7]}});
      OP_PASS: q = d;
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift8_seq.sv
// shift8_seq
//   Sequential 8-bit shift unit. Accepts a total shift of 0-7 and
//   applies it in steps of at most 3 through one shifter8 stage,
//   registering the stage output back into the working register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : start/done handshake (slave side), see shift8_seq_if
//   Latency: N = max(1, ceil(shamt/3)) SHIFT cycles, then a one-cycle
//   done pulse; a start during done begins the next operation at once.
module shift8_seq
  import shift8_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  shift8_seq_if.slave  bus
);

  state_e     state, state_d;
  logic [7:0] work, work_d;
  logic [2:0] rem, rem_d;
  op_e        op_r, op_d;

  logic [1:0] rem_step;
  logic [1:0] shift_step;
  logic [2:0] rem_next;
  logic [7:0] shifted;

  // Pass always finishes after one step-0 cycle regardless of the
  // latched amount, so its remaining count is cleared rather than
  // decremented (a step of 0 would otherwise never drain it).
  assign rem_step   = clamp_step(rem);
  assign shift_step = (op_r == OP_PASS) ? 2'd0 : rem_step;
  assign rem_next   = (op_r == OP_PASS) ? 3'd0 : (rem - {1'b0, rem_step});

  shifter8 u_shifter (
    .d  (work),
    .op (op_r),
    .sh (shift_step),
    .q  (shifted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      work  <= '0;
      rem   <= '0;
      op_r  <= OP_LSL;
    end else begin
      state <= state_d;
      work  <= work_d;
      rem   <= rem_d;
      op_r  <= op_d;
    end
  end

  always_comb begin
    state_d = state;
    work_d  = work;
    rem_d   = rem;
    op_d    = op_r;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          work_d  = bus.d_in;
          rem_d   = bus.shamt;
          op_d    = op_e'(bus.op);
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_next;
        if (rem_next == 3'd0) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy  = (state == ST_SHIFT);
  assign bus.done  = (state == ST_DONE);
  assign bus.d_out = work;

endmodule
